// File: rtl/mcp4921_dac.sv
// Write-only SPI (mode 0) master for the MCP4921 12-bit DAC: one 16-bit frame per
// sample_clk rising edge, followed by an LDAC pulse so the analog output updates in step.
module mcp4921_dac #(
  parameter int CLKS_PER_HALF_BIT = 6,
  parameter bit BUF               = 1'b1,
  parameter bit GA_N              = 1'b1,
  parameter bit SHDN_N            = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_clk,
  input  logic [11:0] data_in,
  output logic        busy,
  output logic        dropped,
  output logic        SCK_PIN,
  output logic        MOSI_PIN,
  output logic        CS_PIN,
  output logic        LDAC_PIN
);

  localparam int CW = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_GAP,
    LDAC_PULSE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bit_idx, bit_d;
  logic [15:0]   word, word_d;
  logic          pending, pending_d;
  logic [11:0]   pend_data, pend_data_d;
  logic          last_sample_clk;
  logic          busy_d, dropped_d, sck_d, mosi_d, cs_d, ldac_d;
  logic          sample_edge, half_done, last_window;

  function automatic logic [15:0] make_word(input logic [11:0] d);
    return {1'b0, BUF, GA_N, SHDN_N, d};
  endfunction

  assign sample_edge = sample_clk & ~last_sample_clk;
  assign half_done   = (cnt == HALF_LAST);
  // The final LDAC cycle hands an incoming edge straight to the next frame.
  assign last_window = (state == LDAC_PULSE) && half_done;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state;
    cnt_d       = cnt;
    bit_d       = bit_idx;
    word_d      = word;
    pending_d   = pending;
    pend_data_d = pend_data;
    busy_d      = busy;
    dropped_d   = 1'b0;
    sck_d       = SCK_PIN;
    mosi_d      = MOSI_PIN;
    cs_d        = CS_PIN;
    ldac_d      = LDAC_PIN;

    if (state != IDLE) cnt_d = half_done ? '0 : cnt + 1'b1;

    if (sample_edge && busy && !last_window) begin
      pending_d   = 1'b1;
      pend_data_d = data_in;
      dropped_d   = pending;
    end

    case (state)
      IDLE: begin
        if (sample_edge) begin
          word_d  = make_word(data_in);
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = word_d[15];
          cnt_d   = '0;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (half_done) begin
          bit_d   = 4'd15;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (half_done) begin
          if (!SCK_PIN) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_idx == 4'd0) begin
              state_d = CS_HOLD;
            end else begin
              bit_d  = bit_idx - 4'd1;
              mosi_d = word[bit_d];
            end
          end
        end
      end
      CS_HOLD: begin
        if (half_done) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = CS_GAP;
        end
      end
      CS_GAP: begin
        if (half_done) begin
          ldac_d  = 1'b0;
          state_d = LDAC_PULSE;
        end
      end
      LDAC_PULSE: begin
        if (half_done) begin
          ldac_d = 1'b1;
          if (sample_edge || pending) begin
            word_d    = sample_edge ? make_word(data_in) : make_word(pend_data);
            dropped_d = sample_edge && pending;
            pending_d = 1'b0;
            cs_d      = 1'b0;
            mosi_d    = word_d[15];
            state_d   = CS_SETUP;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= 4'd0;
      word            <= 16'h0000;
      pending         <= 1'b0;
      pend_data       <= 12'h000;
      last_sample_clk <= 1'b1;
      busy            <= 1'b0;
      dropped         <= 1'b0;
      SCK_PIN         <= 1'b0;
      MOSI_PIN        <= 1'b0;
      CS_PIN          <= 1'b1;
      LDAC_PIN        <= 1'b1;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      bit_idx         <= bit_d;
      word            <= word_d;
      pending         <= pending_d;
      pend_data       <= pend_data_d;
      last_sample_clk <= sample_clk;
      busy            <= busy_d;
      dropped         <= dropped_d;
      SCK_PIN         <= sck_d;
      MOSI_PIN        <= mosi_d;
      CS_PIN          <= cs_d;
      LDAC_PIN        <= ldac_d;
    end
  end

endmodule

// File: tb/tb_mcp4921_dac.sv
// Bench for mcp4921_dac: a pin-level monitor decodes frames, LDAC and busy timing, and
// tests compare them against frames predicted from the command-word and buffering rules.
module tb_mcp4921_dac;
  localparam int H = 6;

  logic        clk = 1'b0, reset = 1'b1, sample_clk = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic        busy, dropped, sck, mosi, cs, ldac;
  logic        b_busy, b_dropped, b_sck, b_mosi, b_cs, b_ldac;
  int          checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcp4921_dac #(.CLKS_PER_HALF_BIT(H), .BUF(1'b1), .GA_N(1'b1), .SHDN_N(1'b1)) dut (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .data_in(data_in),
    .busy(busy), .dropped(dropped), .SCK_PIN(sck), .MOSI_PIN(mosi), .CS_PIN(cs), .LDAC_PIN(ldac)
  );

  mcp4921_dac #(.CLKS_PER_HALF_BIT(H), .BUF(1'b0), .GA_N(1'b0), .SHDN_N(1'b1)) dut_b (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .data_in(data_in),
    .busy(b_busy), .dropped(b_dropped), .SCK_PIN(b_sck), .MOSI_PIN(b_mosi), .CS_PIN(b_cs),
    .LDAC_PIN(b_ldac)
  );

  function automatic logic [15:0] exp_word(input bit bf, input bit ga, input bit sd,
                                           input logic [11:0] d);
    return {1'b0, bf, ga, sd, d};
  endfunction

  // Pin monitor state
  logic        p_cs = 1'b1, p_sck = 1'b0, p_ldac = 1'b1, p_busy = 1'b0;
  logic        pb_cs = 1'b1, pb_sck = 1'b0;
  logic [15:0] sh = '0, b_sh = '0;
  int          nbits = 0, busy_len = 0, ldac_len = 0, drop_cnt = 0;
  logic [15:0] fr_word[$], b_fr_word[$];
  int          fr_bits[$], cs_fall_t[$], cs_rise_t[$], ldac_fall_t[$], ldac_rise_t[$];
  int          ldac_len_q[$], busy_len_q[$];

  always @(negedge clk) begin
    if (p_cs && !cs) begin cs_fall_t.push_back(cyc); nbits = 0; sh = '0; end
    if (!p_sck && sck && !cs) begin sh = {sh[14:0], mosi}; nbits++; end
    if (!p_cs && cs) begin fr_word.push_back(sh); fr_bits.push_back(nbits); cs_rise_t.push_back(cyc); end
    if (p_ldac && !ldac) begin ldac_fall_t.push_back(cyc); ldac_len = 0; end
    if (!ldac) ldac_len++;
    if (!p_ldac && ldac) begin ldac_len_q.push_back(ldac_len); ldac_rise_t.push_back(cyc); end
    if (busy) busy_len++;
    else if (p_busy) begin busy_len_q.push_back(busy_len); busy_len = 0; end
    if (dropped) drop_cnt++;
    if (pb_cs && !b_cs) b_sh = '0;
    if (!pb_sck && b_sck && !b_cs) b_sh = {b_sh[14:0], b_mosi};
    if (!pb_cs && b_cs) b_fr_word.push_back(b_sh);
    p_cs = cs; p_sck = sck; p_ldac = ldac; p_busy = busy; pb_cs = b_cs; pb_sck = b_sck;
  end

  task automatic clear_q();
    fr_word.delete(); fr_bits.delete(); cs_fall_t.delete(); cs_rise_t.delete();
    ldac_fall_t.delete(); ldac_rise_t.delete(); ldac_len_q.delete(); busy_len_q.delete();
    b_fr_word.delete(); drop_cnt = 0;
  endtask

  task automatic pulse(input logic [11:0] d);
    @(negedge clk); sample_clk = 1'b1; data_in = d;
    @(negedge clk); sample_clk = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (busy && n < budget);
    if (busy) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cs !== 1'b1) begin failures++; $display("FAIL rst_cs: got %b exp 1", cs); end
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL rst_sck: got %b exp 0", sck); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi: got %b exp 0", mosi); end
    checks++; if (ldac !== 1'b1) begin failures++; $display("FAIL rst_ldac: got %b exp 1", ldac); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL rst_dropped: got %b exp 0", dropped); end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    clear_q();
    pulse(12'hABC);
    wait_idle(400);
    checks++; if (fr_word[0] !== 16'h7ABC) begin failures++; $display("FAIL single_word: got %h exp 7abc", fr_word[0]); end
    checks++; if (fr_bits[0] != 16) begin failures++; $display("FAIL single_sck_edges: got %0d exp 16", fr_bits[0]); end
    checks++; if (busy_len_q[0] != 36 * H) begin failures++; $display("FAIL single_busy_len: got %0d exp %0d", busy_len_q[0], 36 * H); end
    checks++; if (ldac_len_q[0] != H) begin failures++; $display("FAIL single_ldac_len: got %0d exp %0d", ldac_len_q[0], H); end
    checks++; if (ldac_fall_t[0] - cs_rise_t[0] != H) begin failures++; $display("FAIL single_ldac_gap: got %0d exp %0d", ldac_fall_t[0] - cs_rise_t[0], H); end
    checks++; if (drop_cnt != 0) begin failures++; $display("FAIL single_dropped: got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_params();
    clear_q();
    pulse(12'h0FF);
    wait_idle(400);
    checks++; if (b_fr_word[0] !== 16'h10FF) begin failures++; $display("FAIL params_word: got %h exp 10ff", b_fr_word[0]); end
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 6; i++) begin
      logic [11:0] d = 12'($urandom);
      clear_q();
      pulse(d);
      wait_idle(400);
      checks++; if (fr_word[0] !== exp_word(1, 1, 1, d)) begin failures++; $display("FAIL rand_word: got %h exp %h", fr_word[0], exp_word(1, 1, 1, d)); end
      checks++; if (b_fr_word[0] !== exp_word(0, 0, 1, d)) begin failures++; $display("FAIL rand_word_b: got %h exp %h", b_fr_word[0], exp_word(0, 0, 1, d)); end
      checks++; if (busy_len_q[0] != 36 * H) begin failures++; $display("FAIL rand_busy_len: got %0d exp %0d", busy_len_q[0], 36 * H); end
      checks++; if (fr_bits[0] != 16) begin failures++; $display("FAIL rand_sck_edges: got %0d exp 16", fr_bits[0]); end
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    pulse(12'h123);
    repeat (98) @(negedge clk);
    pulse(12'h456);
    wait_idle(800);
    checks++; if (fr_word.size() != 2) begin failures++; $display("FAIL b2b_frames: got %0d exp 2", fr_word.size()); end
    checks++; if (fr_word[0] !== 16'h7123) begin failures++; $display("FAIL b2b_word0: got %h exp 7123", fr_word[0]); end
    checks++; if (fr_word[1] !== 16'h7456) begin failures++; $display("FAIL b2b_word1: got %h exp 7456", fr_word[1]); end
    checks++; if (busy_len_q.size() != 1 || busy_len_q[0] != 72 * H) begin failures++; $display("FAIL b2b_busy: got %0d stretches first %0d exp 1 of %0d", busy_len_q.size(), busy_len_q[0], 72 * H); end
    checks++; if (cs_fall_t[1] != ldac_rise_t[0]) begin failures++; $display("FAIL b2b_restart_cycle: got %0d exp %0d", cs_fall_t[1], ldac_rise_t[0]); end
    checks++; if (drop_cnt != 0) begin failures++; $display("FAIL b2b_dropped: got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_overwrite();
    clear_q();
    pulse(12'h111);
    repeat (48) @(negedge clk);
    pulse(12'h222);
    repeat (38) @(negedge clk);
    pulse(12'h333);
    wait_idle(800);
    checks++; if (drop_cnt != 1) begin failures++; $display("FAIL ovw_dropped: got %0d exp 1", drop_cnt); end
    checks++; if (fr_word.size() != 2) begin failures++; $display("FAIL ovw_frames: got %0d exp 2", fr_word.size()); end
    checks++; if (fr_word[0] !== 16'h7111) begin failures++; $display("FAIL ovw_word0: got %h exp 7111", fr_word[0]); end
    checks++; if (fr_word[1] !== 16'h7333) begin failures++; $display("FAIL ovw_word1: got %h exp 7333", fr_word[1]); end
  endtask

  // Three edges in one busy window: the 1-deep buffer keeps only the newest sample.
  task automatic test_random_overlap();
    for (int i = 0; i < 4; i++) begin
      logic [11:0] a = 12'($urandom), b = 12'($urandom), c = 12'($urandom);
      clear_q();
      pulse(a);
      repeat ($urandom_range(2, 100)) @(negedge clk);
      pulse(b);
      repeat ($urandom_range(2, 100)) @(negedge clk);
      pulse(c);
      wait_idle(800);
      checks++; if (fr_word.size() != 2 || fr_word[0] !== exp_word(1, 1, 1, a) || fr_word[1] !== exp_word(1, 1, 1, c)) begin
        failures++; $display("FAIL rovl_frames: got %0d frames %h %h exp %h %h", fr_word.size(), fr_word[0], fr_word[1], exp_word(1, 1, 1, a), exp_word(1, 1, 1, c));
      end
      checks++; if (drop_cnt != 1) begin failures++; $display("FAIL rovl_dropped: got %0d exp 1", drop_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    pulse(12'($urandom));
    repeat (58) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if ({cs, sck, ldac, busy, mosi} !== 5'b10100) begin failures++; $display("FAIL rstmid_outputs: got cs,sck,ldac,busy,mosi=%b exp 10100", {cs, sck, ldac, busy, mosi}); end
    reset = 1'b0;
    clear_q();
    repeat (300) @(negedge clk);
    #1;
    checks++; if (ldac_fall_t.size() != 0 || cs_fall_t.size() != 0) begin failures++; $display("FAIL rstmid_quiet: got %0d ldac pulses %0d frames exp 0 0", ldac_fall_t.size(), cs_fall_t.size()); end
    pulse(12'h800);
    wait_idle(400);
    checks++; if (fr_word[0] !== 16'h7800 || fr_bits[0] != 16) begin failures++; $display("FAIL rstmid_clean: got %h/%0d bits exp 7800/16", fr_word[0], fr_bits[0]); end
    checks++; if (ldac_len_q.size() != 1) begin failures++; $display("FAIL rstmid_ldac: got %0d pulses exp 1", ldac_len_q.size()); end
  endtask

  task automatic test_held_high();
    logic [11:0] d = 12'($urandom);
    @(negedge clk); reset = 1'b1; sample_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_q();
    repeat (50) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || cs_fall_t.size() != 0) begin failures++; $display("FAIL held_no_start: got busy %b frames %0d exp 0 0", busy, cs_fall_t.size()); end
    @(negedge clk); sample_clk = 1'b0;
    pulse(d);
    wait_idle(400);
    checks++; if (fr_word.size() != 1 || fr_word[0] !== exp_word(1, 1, 1, d)) begin failures++; $display("FAIL held_frame: got %0d frames %h exp 1 %h", fr_word.size(), fr_word[0], exp_word(1, 1, 1, d)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_params();
    test_random_single();
    test_back_to_back();
    test_overwrite();
    test_random_overlap();
    test_reset_mid();
    test_held_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
